// File: rtl/fir_mac_engine.sv
// fir_mac_engine
//   Multiply-accumulate datapath behind the FIR control FSM. A FirStart pulse
//   launches one pass computing y = sum h[k]*x[XBase-k], k = 0..TAPS-1, reading
//   samples and coefficients from two synchronous 1-cycle-latency memories.
//   FirEnd pulses once when the accumulator is final; FirOe latches the
//   rounded/scaled accumulator onto FirOut.
//
//   Optional feature macro: FIR_SAT_EN
//     defined   -> output saturates to DW bits, FirOvf is a sticky clamp flag
//     undefined -> output wraps to DW bits, FirOvf tied 0
//
// Ports
//   clk, reset          clock (rising edge), async active-low reset
//   FirStart, XBase     start pulse (clears acc, restarts pass), newest sample addr
//   FirOe               latch scaled acc into FirOut this cycle
//   XAddr, CAddr, RdEn  sample/coefficient read address, shared read enable
//   XData, CData        read data, valid one cycle after RdEn
//   FirEnd, FirBusy     pass-complete pulse, pass in progress
//   FirOut, FirValid    registered scaled result and its update strobe
//   FirOvf              sticky saturation flag
module fir_mac_engine #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 32,
  parameter int AW    = 10,
  parameter int KW    = 5,
  parameter int ACCW  = 40,
  parameter int SHIFT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          FirStart,
  input  logic          FirOe,
  input  logic [AW-1:0] XBase,
  output logic [AW-1:0] XAddr,
  output logic [KW-1:0] CAddr,
  output logic          RdEn,
  input  logic [DW-1:0] XData,
  input  logic [CW-1:0] CData,
  output logic          FirEnd,
  output logic          FirBusy,
  output logic [DW-1:0] FirOut,
  output logic          FirValid,
  output logic          FirOvf
);

  localparam int PW = DW + CW;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [AW-1:0]           xbase_q, xbase_d;
  logic                    drn_q, drn_d;
  // [0]: read data valid this cycle, [1]: product register valid this cycle
  logic [1:0]              vld_pipe_q, vld_pipe_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [DW-1:0]           fir_out_q, fir_out_d;
  logic                    fir_valid_q, fir_valid_d;
  logic signed [ACCW-1:0]  r;
  logic [DW-1:0]           fit;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      xbase_q <= '0;
      drn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      xbase_q <= xbase_d;
      drn_q   <= drn_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // FirStart wins in every state, which is what makes a restart abort the pass.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    xbase_d = xbase_q;
    drn_d   = drn_q;
    if (FirStart) begin
      state_d = S_ISSUE;
      k_d     = '0;
      xbase_d = XBase;
    end else begin
      unique case (state_q)
        S_ISSUE: begin
          if (k_q == K_LAST) begin
            state_d = S_DRAIN;
            drn_d   = 1'b0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drn_q) state_d = S_DONE;
          else       drn_d   = 1'b1;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    RdEn    = (state_q == S_ISSUE);
    FirBusy = (state_q != S_IDLE);
    FirEnd  = (state_q == S_DONE);
    CAddr   = k_q;
    // Subtraction in AW bits gives the circular wrap below address 0.
    XAddr   = xbase_q - AW'(k_q);
  end

  // ---------------- MAC datapath ----------------
  // A restart flushes in-flight reads/products so nothing from the aborted
  // pass lands in the freshly cleared accumulator.
  always_comb begin
    vld_pipe_d = FirStart ? 2'b00 : {vld_pipe_q[0], RdEn};
    prod_d     = vld_pipe_q[0] ? PW'($signed(XData) * $signed(CData)) : prod_q;
    acc_d      = acc_q;
    if (FirStart)
      acc_d = '0;
    else if (vld_pipe_q[1])
      acc_d = acc_q + {{(ACCW-PW){prod_q[PW-1]}}, prod_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
    end
  end

  // ---------------- output scaling ----------------
  generate
    if (SHIFT == 0) begin : g_noround
      assign r = acc_q;
    end else begin : g_round
      // Add half an LSB of the result before the arithmetic shift: round half up.
      localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (SHIFT - 1);
      assign r = (acc_q + HALF) >>> SHIFT;
    end
  endgenerate

`ifdef FIR_SAT_EN
  localparam logic signed [ACCW-1:0] OUT_MAX = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] OUT_MIN = ACCW'(-(2 ** (DW - 1)));

  logic clamp;
  logic ovf_q, ovf_d;

  always_comb begin
    fit   = r[DW-1:0];
    clamp = 1'b0;
    if (r > OUT_MAX) begin
      fit   = {1'b0, {(DW-1){1'b1}}};
      clamp = 1'b1;
    end else if (r < OUT_MIN) begin
      fit   = {1'b1, {(DW-1){1'b0}}};
      clamp = 1'b1;
    end
  end

  // FirStart clears the flag; a clamp in the same cycle still sets it.
  always_comb begin
    ovf_d = (FirStart ? 1'b0 : ovf_q) | (FirOe & clamp);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign FirOvf = ovf_q;
`else
  logic unused_hi;
  assign fit       = r[DW-1:0];
  assign unused_hi = ^r[ACCW-1:DW];
  assign FirOvf    = 1'b0;
`endif

  // FirOut samples the pre-start acc when FirStart and FirOe coincide.
  always_comb begin
    fir_out_d   = FirOe ? fit : fir_out_q;
    fir_valid_d = FirOe;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fir_out_q   <= '0;
      fir_valid_q <= 1'b0;
    end else begin
      fir_out_q   <= fir_out_d;
      fir_valid_q <= fir_valid_d;
    end
  end

  assign FirOut   = fir_out_q;
  assign FirValid = fir_valid_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: two instances (SHIFT=0 and SHIFT=1, TAPS=4) share
// stimulus; a behavioural model predicts every output each cycle, and directed
// cases pin literal values.
module tb_fir_mac_engine;
  localparam int DW = 16, CW = 16, TAPS = 4, AW = 10, KW = 2, ACCW = 40;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          FirStart = 1'b0, FirOe = 1'b0;
  logic [AW-1:0] XBase = '0;

  logic [AW-1:0] xa0, xa1;
  logic [KW-1:0] ca0, ca1;
  logic          rd0, rd1, end0, end1, busy0, busy1, val0, val1, ovf0, ovf1;
  logic [DW-1:0] xd0, xd1, out0, out1;
  logic [CW-1:0] cd0, cd1;

  logic [DW-1:0] xmem [0:(1<<AW)-1];
  logic [CW-1:0] hmem [0:TAPS-1];

  fir_mac_engine #(.DW(DW), .CW(CW), .TAPS(TAPS), .AW(AW), .KW(KW), .ACCW(ACCW), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .FirStart(FirStart), .FirOe(FirOe), .XBase(XBase),
    .XAddr(xa0), .CAddr(ca0), .RdEn(rd0), .XData(xd0), .CData(cd0),
    .FirEnd(end0), .FirBusy(busy0), .FirOut(out0), .FirValid(val0), .FirOvf(ovf0));

  fir_mac_engine #(.DW(DW), .CW(CW), .TAPS(TAPS), .AW(AW), .KW(KW), .ACCW(ACCW), .SHIFT(1)) u_dut1 (
    .clk(clk), .reset(reset), .FirStart(FirStart), .FirOe(FirOe), .XBase(XBase),
    .XAddr(xa1), .CAddr(ca1), .RdEn(rd1), .XData(xd1), .CData(cd1),
    .FirEnd(end1), .FirBusy(busy1), .FirOut(out1), .FirValid(val1), .FirOvf(ovf1));

  // Synchronous 1-cycle-latency memories, one read port per instance.
  always @(posedge clk) begin
    if (rd0) begin xd0 <= xmem[xa0]; cd0 <= hmem[ca0]; end
    if (rd1) begin xd1 <= xmem[xa1]; cd1 <= hmem[ca1]; end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint sum_taps(input logic [AW-1:0] b);
    longint s = 0;
    logic [AW-1:0] a;
    for (int k = 0; k < TAPS; k++) begin
      a = b - AW'(k);
      s += longint'($signed(hmem[k])) * longint'($signed(xmem[a]));
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] fit_m(input longint acc, input int sh, output bit clamp);
    longint r;
    logic [63:0] rv;
    r = (sh == 0) ? acc : ((acc + (64'sd1 <<< (sh - 1))) >>> sh);
    rv = r;
    clamp = 1'b0;
`ifdef FIR_SAT_EN
    if (r > 32767)  begin clamp = 1'b1; return 16'h7FFF; end
    if (r < -32768) begin clamp = 1'b1; return 16'h8000; end
`endif
    return rv[DW-1:0];
  endfunction

  bit            active = 0;
  int            age = 0;
  longint        acc_m = 0, pend_m = 0;
  logic [AW-1:0] xb_m = '0;
  logic [DW-1:0] eo0 = '0, eo1 = '0;
  bit            ev = 0, eovf0 = 0, eovf1 = 0;

  // age counts clock edges since the start edge; cycle number = age+1.
  initial forever begin
    bit c0, c1;
    @(posedge clk or negedge reset);
    if (!reset) begin
      active = 0; age = 0; acc_m = 0; eo0 = '0; eo1 = '0; ev = 0; eovf0 = 0; eovf1 = 0;
    end else begin
      ev = FirOe;
      c0 = 0; c1 = 0;
      if (FirOe) begin
        eo0 = fit_m(acc_m, 0, c0);
        eo1 = fit_m(acc_m, 1, c1);
      end
      if (FirStart) begin eovf0 = 0; eovf1 = 0; end
      eovf0 |= c0;
      eovf1 |= c1;
      if (active) begin
        age++;
        if (age == TAPS + 2) acc_m = pend_m;
        if (age > TAPS + 2)  active = 0;
      end
      if (FirStart) begin
        active = 1; age = 0; xb_m = XBase; pend_m = sum_taps(XBase); acc_m = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic [AW-1:0] ea;
    bit erd;
    @(negedge clk);
    erd = active && (age < TAPS);
    ea  = xb_m - AW'(age);
    chk("rden0", rd0, erd);
    chk("rden1", rd1, erd);
    chk("busy0", busy0, active);
    chk("busy1", busy1, active);
    chk("end0", end0, active && (age == TAPS + 2));
    chk("end1", end1, active && (age == TAPS + 2));
    if (erd) begin
      chk("caddr", ca0, age);
      chk("xaddr", xa0, ea);
    end
    chk("valid0", val0, ev);
    chk("valid1", val1, ev);
    chk("out0", out0, eo0);
    chk("out1", out1, eo1);
    chk("ovf0", ovf0, eovf0);
    chk("ovf1", ovf1, eovf1);
  end

  // ---------------- stimulus ----------------
  task automatic cyc1();
    @(posedge clk); #2;
  endtask

  task automatic pulse(input logic [AW-1:0] b, input bit oe);
    FirStart = 1'b1; FirOe = oe; XBase = b;
    cyc1();
    FirStart = 1'b0; FirOe = 1'b0; XBase = AW'($urandom);
  endtask

  task automatic oe_pulse();
    FirOe = 1'b1;
    cyc1();
    FirOe = 1'b0;
  endtask

  task automatic fill_x(input logic [DW-1:0] v);
    for (int i = 0; i < (1 << AW); i++) xmem[i] = v;
  endtask

  initial begin
    int e_cnt, e_cyc, dly;
    fill_x('0);
    for (int k = 0; k < TAPS; k++) hmem[k] = '0;

    #12;
    chk("rst_xaddr", xa0, 0);
    chk("rst_caddr", ca0, 0);
    chk("rst_rden", rd0, 0);
    chk("rst_out", out0, 0);
    chk("rst_valid", val0, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    cyc1();

    // h={1,2,3,4}, x=1: FirEnd only at cycle 7, FirOut=10
    for (int k = 0; k < TAPS; k++) hmem[k] = DW'(k + 1);
    fill_x(16'd1);
    pulse(10'd100, 1'b0);
    e_cnt = 0; e_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) chk("t1_caddr_k3", ca0, 3);
      if (end0) begin e_cnt++; e_cyc = c; end
      cyc1();
    end
    chk("t1_end_cycle", e_cyc, 7);
    chk("t1_end_count", e_cnt, 1);
    oe_pulse();
    chk("t1_firout", out0, 10);
    chk("t1_firvalid", val0, 1);
    cyc1();
    chk("t1_hold", out0, 10);

    // circular address wrap below 0
    fill_x('0);
    xmem[0] = 16'd5; xmem[1023] = 16'd7;
    hmem[0] = 16'd1; hmem[1] = 16'd1; hmem[2] = '0; hmem[3] = '0;
    pulse(10'd0, 1'b0);
    cyc1();
    chk("t2_xaddr_wrap", xa0, 1023);
    repeat (8) cyc1();
    oe_pulse();
    chk("t2_firout", out0, 12);

    // full-scale products: saturate or wrap
    fill_x(16'h7FFF);
    for (int k = 0; k < TAPS; k++) hmem[k] = 16'h7FFF;
    pulse(10'd500, 1'b0);
    repeat (9) cyc1();
    oe_pulse();
`ifdef FIR_SAT_EN
    chk("t3_firout_sat", out0, 16'h7FFF);
    chk("t3_ovf_sat", ovf0, 1);
`else
    chk("t3_firout_wrap", out0, 16'h0004);
    chk("t3_ovf_wrap", ovf0, 0);
`endif

    // rounding with SHIFT=1
    fill_x(16'd1);
    hmem[0] = 16'd1; hmem[1] = 16'd2; hmem[2] = '0; hmem[3] = '0;
    pulse(10'd50, 1'b0);
    repeat (9) cyc1();
    oe_pulse();
    chk("t4_pos_shift1", out1, 2);
    chk("t4_pos_shift0", out0, 3);
    hmem[0] = 16'hFFFF; hmem[1] = 16'hFFFE;
    pulse(10'd50, 1'b0);
    repeat (9) cyc1();
    oe_pulse();
    chk("t4_neg_shift1", out1, 16'hFFFF);
    chk("t4_neg_shift0", out0, 16'hFFFD);

    // restart at cycle 3: single FirEnd at cycle 10, no stale partial sum
    for (int k = 0; k < TAPS; k++) hmem[k] = DW'(k + 1);
    pulse(10'd100, 1'b0);
    cyc1();
    cyc1();
    pulse(10'd100, 1'b0);
    e_cnt = 0; e_cyc = 0;
    for (int c = 4; c <= 15; c++) begin
      if (end0) begin e_cnt++; e_cyc = c; end
      cyc1();
    end
    chk("t5_end_cycle", e_cyc, 10);
    chk("t5_end_count", e_cnt, 1);
    oe_pulse();
    chk("t5_firout", out0, 10);

    // reset mid-pass
    pulse(10'd100, 1'b0);
    cyc1();
    #1 reset = 1'b0;
    #1;
    chk("t6_rden", rd0, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_end", end0, 0);
    chk("t6_out", out0, 0);
    cyc1();
    reset = 1'b1;
    e_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (end0) e_cnt++;
      cyc1();
    end
    chk("t6_no_end", e_cnt, 0);

    // randomized passes against the model
    for (int it = 0; it < 40; it++) begin
      int mode;
      for (int k = 0; k < TAPS; k++) hmem[k] = CW'($urandom);
      for (int i = 0; i < (1 << AW); i++) xmem[i] = DW'($urandom);
      mode = $urandom_range(0, 3);
      pulse(AW'($urandom), mode == 0);
      if (mode == 1) begin
        dly = $urandom_range(0, TAPS + 1);
        repeat (dly) cyc1();
        pulse(AW'($urandom), 1'b0);
      end
      repeat (TAPS + 4) cyc1();
      FirOe = 1'b1;
      repeat ($urandom_range(1, 3)) cyc1();
      FirOe = 1'b0;
      repeat ($urandom_range(0, 2)) cyc1();
    end

    cyc1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
